i2c_init_seq: RTL

I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

---
 rtl/i2c_reg_pkg.sv | 14 +
 rtl/tlul_pkg.sv | 61 ++++++
 rtl/i2c_init_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_pkg.sv
// I2C host register offsets written by i2c_init_seq (OpenTitan i2c register map).
package i2c_reg_pkg;

    parameter logic [6:0] I2C_CTRL_OFFSET         = 7'h10;
    parameter logic [6:0] I2C_FDATA_OFFSET        = 7'h1c;
    parameter logic [6:0] I2C_FIFO_CTRL_OFFSET    = 7'h20;
    parameter logic [6:0] I2C_TIMING0_OFFSET      = 7'h30;
    parameter logic [6:0] I2C_TIMING1_OFFSET      = 7'h34;
    parameter logic [6:0] I2C_TIMING2_OFFSET      = 7'h38;
    parameter logic [6:0] I2C_TIMING3_OFFSET      = 7'h3c;
    parameter logic [6:0] I2C_TIMING4_OFFSET      = 7'h40;
    parameter logic [6:0] I2C_TIMEOUT_CTRL_OFFSET = 7'h44;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL request/response types used by i2c_init_seq (subset matching the OpenTitan tlul_pkg layout).
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    // instr_type 4'h9 is the multi-bit "false" encoding: data access, not instruction fetch
    parameter tl_a_user_t TL_A_USER_DEFAULT = '{
        rsvd:       5'h0,
        instr_type: 4'h9,
        cmd_intg:   7'h0,
        data_intg:  7'h0
    };

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/i2c_init_seq.sv
// Issues the ten-write I2C host bring-up sequence over TL-UL, one transaction outstanding at a time.
// Define I2C_INIT_SEQ_TIMEOUT_EN to abort with an error when a response takes RspTimeout cycles.
module i2c_init_seq #(
    parameter logic [31:0] BaseAddr       = 32'h0,
    parameter logic [31:0] Timing0Val     = 32'h000A_0003,
    parameter logic [31:0] Timing1Val     = 32'h0003_0001,
    parameter logic [31:0] Timing2Val     = 32'h0001_0001,
    parameter logic [31:0] Timing3Val     = 32'h0002_0004,
    parameter logic [31:0] Timing4Val     = 32'h0004_0003,
    parameter logic [31:0] TimeoutCtrlVal = 32'h1,
    parameter int unsigned RspTimeout     = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [12:0]       fdata_i,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [3:0]        step_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RSP,
        DONE,
        ERR
    } state_e;

    localparam logic [3:0] LastStep = 4'd9;

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [12:0] fdata_q, fdata_d;
    logic        err_q, err_d;
    logic        rsp_expired;
    logic [6:0]  offset;
    logic [31:0] wdata;

`ifdef I2C_INIT_SEQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(RspTimeout + 1);

    logic [CntW-1:0] wait_cnt_q;

    // Counts cycles spent in RSP without a response; restarts on every RSP entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (state_q == RSP && !tl_i.d_valid) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign rsp_expired = (wait_cnt_q == CntW'(RspTimeout - 1));
`else
    logic unused_timeout;

    assign rsp_expired    = 1'b0;
    assign unused_timeout = ^RspTimeout;
`endif

    logic unused_rsp;
    assign unused_rsp = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                          tl_i.d_sink, tl_i.d_data, tl_i.d_user};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            step_q  <= '0;
            fdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            fdata_q <= fdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fdata_d = fdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = REQ;
                    step_d  = '0;
                    fdata_d = fdata_i;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                // Any d_valid seen here is stale or spurious and is dropped.
                if (tl_i.a_ready) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (step_q == LastStep) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                        step_d  = step_q + 4'd1;
                    end
                end else if (rsp_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            DONE, ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        offset = '0;
        wdata  = '0;
        case (step_q)
            4'd0: begin offset = i2c_reg_pkg::I2C_CTRL_OFFSET;         wdata = 32'd1;              end
            4'd1: begin offset = i2c_reg_pkg::I2C_FIFO_CTRL_OFFSET;    wdata = 32'd387;            end
            4'd2: begin offset = i2c_reg_pkg::I2C_TIMING0_OFFSET;      wdata = Timing0Val;         end
            4'd3: begin offset = i2c_reg_pkg::I2C_TIMING1_OFFSET;      wdata = Timing1Val;         end
            4'd4: begin offset = i2c_reg_pkg::I2C_TIMING2_OFFSET;      wdata = Timing2Val;         end
            4'd5: begin offset = i2c_reg_pkg::I2C_TIMING3_OFFSET;      wdata = Timing3Val;         end
            4'd6: begin offset = i2c_reg_pkg::I2C_TIMING4_OFFSET;      wdata = Timing4Val;         end
            4'd7: begin offset = i2c_reg_pkg::I2C_TIMEOUT_CTRL_OFFSET; wdata = TimeoutCtrlVal;     end
            4'd8: begin offset = i2c_reg_pkg::I2C_FIFO_CTRL_OFFSET;    wdata = 32'd68;             end
            4'd9: begin offset = i2c_reg_pkg::I2C_FDATA_OFFSET;        wdata = {19'b0, fdata_q};   end
            default: begin offset = '0;                                 wdata = '0;                 end
        endcase
    end

    // Request fields depend only on registered state, so they stay stable while a_ready is low.
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = (state_q == REQ);
        tl_o.a_opcode  = tlul_pkg::PutFullData;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = 8'h0;
        tl_o.a_address = BaseAddr + {25'h0, offset};
        tl_o.a_mask    = 4'hf;
        tl_o.a_data    = wdata;
        tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_o.d_ready   = 1'b1;
    end

    assign busy_o = (state_q == REQ) || (state_q == RSP);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;
    assign step_o = step_q;

endmodule
